id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback-to-decode bypass, load-use hazard
// detection, and bubble insertion on flush or stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_d1,
    input  logic [31:0] id_d2,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic [1:0]  id_aluop,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_alusrc,
    output logic [1:0]  ex_aluop,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc4,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst,
    output logic        stall
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned IMMW = 16;

    typedef struct packed {
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic [1:0]      aluop;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc4;
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] dst;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;

    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic [REGW-1:0] id_rd;
    logic [IMMW-1:0] id_imm;
    logic            byp_a;
    logic            byp_b;
    logic            bubble;
    logic            unused_opcode;

    assign id_rs  = id_instr[25:21];
    assign id_rt  = id_instr[20:16];
    assign id_rd  = id_instr[15:11];
    assign id_imm = id_instr[15:0];
    assign unused_opcode = ^id_instr[31:26];

    // r0 is hardwired zero in the bank, so it is never forwarded.
    assign byp_a = wb_regwrite && (wb_reg != REGW'(0)) && (wb_reg == id_rs);
    assign byp_b = wb_regwrite && (wb_reg != REGW'(0)) && (wb_reg == id_rt);

    // Load in EX whose destination is read by the ID instruction.
    assign stall = ex_q.memread && (ex_q.rt != REGW'(0)) &&
                   ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));

    assign bubble = flush || stall;

    // Next-stage payload; a bubble is an all-zero payload.
    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.memtoreg = id_memtoreg;
            ex_d.alusrc   = id_alusrc;
            ex_d.aluop    = id_aluop;
            ex_d.a        = byp_a ? wb_data : id_d1;
            ex_d.b        = byp_b ? wb_data : id_d2;
            ex_d.imm      = {{(XLEN-IMMW){id_imm[IMMW-1]}}, id_imm};
            ex_d.pc4      = id_pc4;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.dst      = id_regdst ? id_rd : id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_aluop    = ex_q.aluop;
    assign ex_a        = ex_q.a;
    assign ex_b        = ex_q.b;
    assign ex_imm      = ex_q.imm;
    assign ex_pc4      = ex_q.pc4;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_dst      = ex_q.dst;

endmodule
